// File: rtl/vga_xor_gen_if.sv
// Signal bundle between the pattern generator and the board: button inputs in,
// sync/colour/enable out. master = generator side, slave = board side.
interface vga_xor_gen_if #(
    parameter int W = 6
);
    logic         but1;
    logic         but2;
    logic         but3;
    logic         hsync;
    logic         vsync;
    logic [W-1:0] rrggbb;
    logic         de;
    logic         frame_start;

    modport master (
        input  but1, but2, but3,
        output hsync, vsync, rrggbb, de, frame_start
    );

    modport slave (
        output but1, but2, but3,
        input  hsync, vsync, rrggbb, de, frame_start
    );
endinterface

// File: rtl/vga_xor_gen.sv
// Parametrised VGA timing generator with debounced button control and a
// four-mode scrolling bit-pattern engine, all in the pixel-clock domain.
module vga_xor_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 128,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 9,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 28,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CBITS      = 2,
    parameter int SHIFT      = 2,
    parameter int SPEED      = 1,
    parameter int DEB_CYCLES = 65536
) (
    input logic           clk,
    input logic           reset_n,
    vga_xor_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int W       = 3 * CBITS;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int CW      = $clog2(DEB_CYCLES + 1);
    localparam int PW      = (SHIFT + W > 10) ? SHIFT + W : 10;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] DEB_END = CW'(DEB_CYCLES - 1);
    localparam logic [9:0]    STEP    = 10'(SPEED);

    typedef enum logic [1:0] {
        MODE_XOR = 2'd0,
        MODE_AND = 2'd1,
        MODE_OR  = 2'd2,
        MODE_CHK = 2'd3
    } mode_e;

    // ---------------- raster counters ----------------
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          wrap;

    // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wrap = (h_q == H_LAST) && (v_q == V_LAST);
        h_d  = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d  = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // ---------------- button conditioning ----------------
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q, deb_q, press_q;
    logic [CW-1:0] deb_cnt_q [3];

    assign btn_raw = {vga.but3, vga.but2, vga.but1};

    // NOTE: clocked blocks use only non-blocking (<=) so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_END) begin
                    // Stable long enough: accept the new level; only a rise is a press.
                    deb_cnt_q[i] <= '0;
                    deb_q[i]     <= sync2_q[i];
                    press_q[i]   <= sync2_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- frame-synchronous control ----------------
    // dir and pause are only ever consumed at the frame boundary, so the
    // pending copies double as the live state; mode feeds every pixel and
    // therefore has its own live register.
    mode_e      mode_q, mode_pend_q, mode_pend_d;
    logic       dir_pend_q, dir_pend_d;
    logic       pause_pend_q, pause_pend_d;
    logic [9:0] off_q, off_d;

    always_comb begin
        mode_pend_d  = mode_e'(mode_pend_q + {1'b0, press_q[0]});
        dir_pend_d   = dir_pend_q ^ press_q[1];
        pause_pend_d = pause_pend_q ^ press_q[2];
        off_d        = off_q;
        if (!pause_pend_d) begin
            off_d = dir_pend_d ? off_q - STEP : off_q + STEP;
        end
    end

    // ---------------- pattern ----------------
    logic [9:0]   x, y, p;
    logic         chk_bit;
    logic         active, hs_act, vs_act;
    logic [W-1:0] rgb_d;

    always_comb begin
        x       = 10'(h_q) + off_q;
        y       = 10'(v_q);
        chk_bit = |((x ^ y) & (10'(1) << (SHIFT + 3)));
        p       = '0;
        unique case (mode_q)
            MODE_XOR: p = x ^ y;
            MODE_AND: p = x & y;
            MODE_OR:  p = x | y;
            default:  p = {10{chk_bit}};
        endcase
        active = (h_q < H_ACT) && (v_q < V_ACT);
        hs_act = (h_q >= H_SS) && (h_q < H_SE);
        vs_act = (v_q >= V_SS) && (v_q < V_SE);
        rgb_d  = active ? W'(PW'(p) >> SHIFT) : '0;
    end

    // ---------------- state and registered outputs ----------------
    logic         hsync_q, vsync_q, de_q, fs_pend_q, frame_start_q;
    logic [W-1:0] rrggbb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= MODE_XOR;
            mode_pend_q   <= MODE_XOR;
            dir_pend_q    <= 1'b0;
            pause_pend_q  <= 1'b0;
            off_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            rrggbb_q      <= '0;
            fs_pend_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            mode_pend_q  <= mode_pend_d;
            dir_pend_q   <= dir_pend_d;
            pause_pend_q <= pause_pend_d;
            if (wrap) begin
                mode_q <= mode_pend_d;
                off_q  <= off_d;
            end
            hsync_q       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vs_act ? SYNC_POL : ~SYNC_POL;
            de_q          <= active;
            rrggbb_q      <= rgb_d;
            // fs_pend_q marks counters sitting at (0,0) after a wrap, not after reset.
            fs_pend_q     <= wrap;
            frame_start_q <= fs_pend_q;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.rrggbb      = rrggbb_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_xor_gen.sv
// Directed bench for vga_xor_gen on a shrunken 64x24 raster with a 16-cycle debounce.
`timescale 1ns/1ps
module tb_vga_xor_gen;
    localparam int HA = 48, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 4, VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    typedef struct {
        int         h;
        int         v;
        logic [5:0] rgb;
        logic       de;
        logic       hs;
        logic       vs;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    vga_xor_gen_if #(.W(6)) vif ();

    vga_xor_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .CBITS(2), .SHIFT(2), .SPEED(1), .DEB_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vga(vif)
    );

    always #5 clk = ~clk;

    // Bench-side raster position: after edge n the outputs describe pixel n-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic vec_t mk(input int h, input int v, input logic [5:0] rgb,
                                input logic de, input logic hs, input logic vs);
        vec_t r;
        r.h = h; r.v = v; r.rgb = rgb; r.de = de; r.hs = hs; r.vs = vs;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic wait_pix(input int f, input int h, input int v);
        int target;
        target = f * FT + v * HT + h + 1;
        if (cyc > target) begin
            n_checks++;
            n_errors++;
            $display("FAIL schedule: at cycle %0d, pixel target %0d already passed", cyc, target);
        end
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pix(input int f, input int h, input int v, input logic [5:0] exp_rgb);
        wait_pix(f, h, v);
        check($sformatf("rgb_f%0d(%0d,%0d)", f, h, v), vif.rrggbb, exp_rgb);
    endtask

    // Mode 0, row 0: rgb = (h+off)>>2, so the 0->1 step sits at h = 4-off (mod 1024).
    task automatic check_off(input int f, input int off);
        pix(f, (3 - off) & 1023, 0, 6'd0);
        pix(f, (4 - off) & 1023, 0, 6'd1);
    endtask

    task automatic set_btn(input int btn, input logic val);
        case (btn)
            1:       vif.but1 = val;
            2:       vif.but2 = val;
            default: vif.but3 = val;
        endcase
    endtask

    task automatic press(input int btn, input int hi_cycles);
        set_btn(btn, 1'b1);
        repeat (hi_cycles) @(negedge clk);
        set_btn(btn, 1'b0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[$];
        int   de_n, hs_n, hs_first, vs_n;

        vif.but1 = 1'b0;
        vif.but2 = 1'b0;
        vif.but3 = 1'b0;

        vecs.push_back(mk( 0,  0, 6'd0, 1, 1, 1));
        vecs.push_back(mk(13,  5, 6'd2, 1, 1, 1));
        vecs.push_back(mk(40, 12, 6'd9, 1, 1, 1));
        vecs.push_back(mk(47, 12, 6'd8, 1, 1, 1));
        vecs.push_back(mk(48, 12, 6'd0, 0, 1, 1));
        vecs.push_back(mk(51, 12, 6'd0, 0, 1, 1));
        vecs.push_back(mk(52, 12, 6'd0, 0, 0, 1));
        vecs.push_back(mk(57, 12, 6'd0, 0, 0, 1));
        vecs.push_back(mk(58, 12, 6'd0, 0, 1, 1));
        vecs.push_back(mk(47, 15, 6'd8, 1, 1, 1));
        vecs.push_back(mk(40, 16, 6'd0, 0, 1, 1));
        vecs.push_back(mk(10, 17, 6'd0, 0, 1, 1));
        vecs.push_back(mk(10, 18, 6'd0, 0, 1, 0));
        vecs.push_back(mk(55, 19, 6'd0, 0, 0, 0));
        vecs.push_back(mk(10, 20, 6'd0, 0, 1, 1));

        // Reset state while held
        repeat (3) @(negedge clk);
        check("rst_hsync", vif.hsync, 1);
        check("rst_vsync", vif.vsync, 1);
        check("rst_rgb", vif.rrggbb, 0);
        check("rst_de", vif.de, 0);
        check("rst_fs", vif.frame_start, 0);
        reset_n = 1'b1;

        // Frame 0: mode 0, off 0
        foreach (vecs[i]) begin
            wait_pix(0, vecs[i].h, vecs[i].v);
            check($sformatf("vec%0d_rgb", i), vif.rrggbb, vecs[i].rgb);
            check($sformatf("vec%0d_de", i), vif.de, vecs[i].de);
            check($sformatf("vec%0d_hsync", i), vif.hsync, vecs[i].hs);
            check($sformatf("vec%0d_vsync", i), vif.vsync, vecs[i].vs);
        end

        while (!vif.frame_start && cyc < 3 * FT) @(negedge clk);
        check("first_frame_start_cycle", cyc, FT + 1);
        @(negedge clk);
        check("frame_start_width", vif.frame_start, 0);

        // Frame 1: off 1, line and frame timing
        check_off(1, 1);
        de_n = 0; hs_n = 0; hs_first = -1; vs_n = 0;
        for (int h = 0; h < HT; h++) begin
            wait_pix(1, h, 2);
            if (vif.de) de_n++;
            if (!vif.hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = h;
            end
        end
        check("line_de_cycles", de_n, HA);
        check("line_hsync_cycles", hs_n, HS);
        check("line_hsync_start", hs_first, HA + HFP);
        for (int v = 3; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                wait_pix(1, h, v);
                if (!vif.vsync) vs_n++;
            end
        end
        check("frame_vsync_cycles", vs_n, VS * HT);

        // Scroll up, then reverse direction and wrap below zero
        check_off(2, 2);
        press(2, 40);
        check_off(3, 1);
        check_off(4, 0);
        check_off(5, 1023);
        // Pause and direction change in one frame: offset must hold
        press(2, 40);
        press(3, 40);
        check_off(6, 1023);
        check_off(7, 1023);
        check_off(8, 1023);
        press(3, 40);
        check_off(9, 0);

        // Debounce: short glitch ignored, long press advances the mode
        press(1, 10);
        pix(10, 40, 12, 6'd9);
        press(1, 40);
        pix(11, 40, 12, 6'd2);

        // Two mode presses accumulate to mode 3; also set dir and pause
        press(1, 40);
        press(1, 40);
        press(2, 40);
        press(3, 40);
        pix(12, 10, 12, 6'd0);
        pix(12, 40, 12, 6'd63);

        // Asynchronous reset in the middle of the sync pulses
        wait_pix(12, 54, 19);
        check("pre_rst_hsync", vif.hsync, 0);
        check("pre_rst_vsync", vif.vsync, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_hsync", vif.hsync, 1);
        check("async_rst_vsync", vif.vsync, 1);
        check("async_rst_rgb", vif.rrggbb, 0);
        check("async_rst_de", vif.de, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Control back to defaults: mode 0, off 0, dir 0, unpaused
        check_off(0, 0);
        pix(0, 40, 12, 6'd9);
        check_off(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
